// File: rtl/fault_map_collector.sv
// rtl/fault_map_collector.sv - sequences one diagnosis pass, builds the NxN fault map and streams it to eNVM
module fault_map_collector #(
    parameter int SYSTOLIC_SIZE = 8,
    parameter int ADDR_WIDTH    = $clog2(SYSTOLIC_SIZE),
    parameter int RUN_CYCLES    = SYSTOLIC_SIZE,
    parameter int CNT_WIDTH     = $clog2(SYSTOLIC_SIZE*SYSTOLIC_SIZE+1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    output logic                     chain_en,
    input  logic [SYSTOLIC_SIZE-1:0] single_pe_detection,
    input  logic [ADDR_WIDTH-1:0]    row_index,
    input  logic [SYSTOLIC_SIZE-1:0] column_fault_detection,
    input  logic [SYSTOLIC_SIZE-1:0] row_fault_detection,
    output logic                     wr_en,
    output logic [ADDR_WIDTH-1:0]    wr_addr,
    output logic [SYSTOLIC_SIZE-1:0] wr_data,
    input  logic                     wr_ready,
    output logic                     busy,
    output logic                     done,
    output logic [SYSTOLIC_SIZE-1:0] col_fault_mask,
    output logic [SYSTOLIC_SIZE-1:0] row_fault_mask,
    output logic [CNT_WIDTH-1:0]     fault_count
);

    localparam int N     = SYSTOLIC_SIZE;
    localparam int RUN_W = $clog2(RUN_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RUN     = 3'd1,
        CAPTURE = 3'd2,
        WRITE   = 3'd3,
        FINISH  = 3'd4
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [N-1:0]         map [N];
    logic [RUN_W-1:0]     run_cnt;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic                 run_last;
    logic                 wr_last;
    logic                 row_valid;
    logic [CNT_WIDTH-1:0] map_popcount;

    assign run_last  = (run_cnt == RUN_W'(RUN_CYCLES - 1));
    assign wr_last   = (wr_ptr == ADDR_WIDTH'(N - 1));
    assign row_valid = (int'(row_index) < N);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (run_last) state_next = CAPTURE;
            CAPTURE: state_next = WRITE;
            WRITE:   if (wr_ready && wr_last) state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs are pure state decodes so nothing combinational reaches them from inputs
    assign chain_en = (state == RUN);
    assign wr_en    = (state == WRITE);
    assign busy     = (state != IDLE);
    assign done     = (state == FINISH);
    assign wr_addr  = wr_ptr;
    assign wr_data  = (state == WRITE) ? map[wr_ptr] : '0;

    always_comb begin
        map_popcount = '0;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                map_popcount = map_popcount + CNT_WIDTH'(map[r][c]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_cnt        <= '0;
            wr_ptr         <= '0;
            col_fault_mask <= '0;
            row_fault_mask <= '0;
            fault_count    <= '0;
            for (int i = 0; i < N; i++) begin
                map[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        run_cnt <= '0;
                        wr_ptr  <= '0;
                        for (int i = 0; i < N; i++) begin
                            map[i] <= '0;
                        end
                    end
                end
                RUN: begin
                    run_cnt <= run_cnt + 1'b1;
                    // Detections are sticky: a row revisited later only adds bits
                    if (row_valid) begin
                        map[row_index] <= map[row_index] | single_pe_detection;
                    end
                end
                CAPTURE: begin
                    col_fault_mask <= column_fault_detection;
                    row_fault_mask <= row_fault_detection;
                    fault_count    <= map_popcount;
                    wr_ptr         <= '0;
                end
                WRITE: begin
                    if (wr_ready) begin
                        wr_ptr <= wr_last ? '0 : wr_ptr + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fault_map_collector.sv
// tb/tb_fault_map_collector.sv - randomized self-checking bench for fault_map_collector
module tb_fault_map_collector;

    localparam int N  = 8;
    localparam int AW = 3;
    localparam int RC = 8;
    localparam int CW = 7;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          chain_en;
    logic [N-1:0]  single_pe_detection = '0;
    logic [AW-1:0] row_index = '0;
    logic [N-1:0]  column_fault_detection = '0;
    logic [N-1:0]  row_fault_detection = '0;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [N-1:0]  wr_data;
    logic          wr_ready = 1'b1;
    logic          busy;
    logic          done;
    logic [N-1:0]  col_fault_mask;
    logic [N-1:0]  row_fault_mask;
    logic [CW-1:0] fault_count;

    int checks = 0;
    int failures = 0;

    // Values the collector is expected to be holding between passes
    int held_col = 0;
    int held_row = 0;
    int held_cnt = 0;

    fault_map_collector #(
        .SYSTOLIC_SIZE(N),
        .RUN_CYCLES(RC)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .chain_en(chain_en),
        .single_pe_detection(single_pe_detection),
        .row_index(row_index),
        .column_fault_detection(column_fault_detection),
        .row_fault_detection(row_fault_detection),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .wr_ready(wr_ready),
        .busy(busy),
        .done(done),
        .col_fault_mask(col_fault_mask),
        .row_fault_mask(row_fault_mask),
        .fault_count(fault_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // mode: 0 clean, 1 single PE, 2 sticky, 3 backpressure, 4 random, 5 reset mid-write
    task automatic do_pass(input int mode);
        logic [N-1:0] m [N];
        logic [N-1:0] colv;
        logic [N-1:0] rowv;
        logic [N-1:0] det;
        int row;
        int cycles;
        int stall;
        int ptr;
        int budget;
        int exp_cnt;
        bit ready;
        bit saw_done;
        for (int i = 0; i < N; i++) m[i] = '0;
        @(negedge clk);
        start  = 1'b1;
        cycles = 1;
        for (int k = 0; k < RC; k++) begin
            @(negedge clk);
            cycles++;
            check_eq("run_chain_en", chain_en, 1);
            check_eq("run_wr_en", wr_en, 0);
            if (k == 0) begin
                check_eq("held_col_mask", col_fault_mask, held_col);
                check_eq("held_row_mask", row_fault_mask, held_row);
                check_eq("held_count", fault_count, held_cnt);
            end
            start = (mode == 4) ? 1'($urandom_range(0, 1)) : (k == 2);
            case (mode)
                1: begin row = k; det = (k == 3) ? 8'h04 : 8'h00; end
                2: begin
                    row = (k == 1 || k == 5) ? 5 : k;
                    det = (k == 1) ? 8'h01 : (k == 5) ? 8'h80 : 8'h00;
                end
                3, 4, 5: begin
                    row = $urandom_range(0, N - 1);
                    det = N'($urandom & $urandom & $urandom);
                end
                default: begin row = k; det = 8'h00; end
            endcase
            row_index           = AW'(row);
            single_pe_detection = det;
            m[row]              = m[row] | det;
        end
        @(negedge clk);
        cycles++;
        check_eq("capture_chain_en", chain_en, 0);
        check_eq("capture_busy", busy, 1);
        start               = 1'b0;
        single_pe_detection = N'($urandom);
        if (mode == 4 || mode == 5) begin
            colv = N'($urandom);
            rowv = N'($urandom);
        end else begin
            colv = 8'h20;
            rowv = 8'h40;
        end
        column_fault_detection = colv;
        row_fault_detection    = rowv;
        exp_cnt = 0;
        for (int i = 0; i < N; i++) exp_cnt += $countones(m[i]);
        ptr    = 0;
        stall  = 0;
        budget = 0;
        while (ptr < N && budget < 200) begin
            @(negedge clk);
            cycles++;
            budget++;
            column_fault_detection = ~colv;
            row_fault_detection    = ~rowv;
            if (mode == 4) start = 1'($urandom_range(0, 1));
            check_eq("write_wr_en", wr_en, 1);
            check_eq("write_addr", wr_addr, ptr);
            check_eq($sformatf("write_data_row%0d", ptr), wr_data, m[ptr]);
            if (budget == 1) begin
                check_eq("col_mask", col_fault_mask, colv);
                check_eq("row_mask", row_fault_mask, rowv);
                check_eq("fault_count", fault_count, exp_cnt);
            end
            if (mode == 5 && ptr == 4) begin
                rst_n = 1'b0;
                #1;
                check_eq("reset_ctrl", {chain_en, wr_en, done, busy}, 0);
                check_eq("reset_wr", {wr_addr, wr_data}, 0);
                check_eq("reset_masks", {col_fault_mask, row_fault_mask, fault_count}, 0);
                held_col = 0;
                held_row = 0;
                held_cnt = 0;
                start    = 1'b0;
                wr_ready = 1'b1;
                @(negedge clk);
                rst_n    = 1'b1;
                saw_done = 1'b0;
                for (int j = 0; j < 25; j++) begin
                    @(negedge clk);
                    if (done || busy) saw_done = 1'b1;
                end
                check_eq("no_done_after_reset", saw_done, 0);
                return;
            end
            case (mode)
                3:       ready = !(ptr == 2 && stall < 5);
                4:       ready = 1'($urandom_range(0, 3) != 0);
                default: ready = 1'b1;
            endcase
            if (!ready) stall++;
            wr_ready = ready;
            if (ready) ptr++;
        end
        check_eq("write_budget", ptr, N);
        @(negedge clk);
        cycles++;
        start    = 1'b0;
        wr_ready = 1'b1;
        check_eq("done_pulse", done, 1);
        check_eq("pass_length", cycles, RC + N + 3 + stall);
        check_eq("done_count", fault_count, exp_cnt);
        check_eq("done_col_mask", col_fault_mask, colv);
        check_eq("done_row_mask", row_fault_mask, rowv);
        if (mode == 3) check_eq("stall_cycles", stall, 5);
        held_col = colv;
        held_row = rowv;
        held_cnt = exp_cnt;
        saw_done = 1'b0;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            if (done || busy) saw_done = 1'b1;
        end
        check_eq("single_pass_only", saw_done, 0);
    endtask

    initial begin
        #1;
        check_eq("reset_ctrl_init", {chain_en, wr_en, done, busy}, 0);
        check_eq("reset_wr_init", {wr_addr, wr_data}, 0);
        check_eq("reset_masks_init", {col_fault_mask, row_fault_mask, fault_count}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        do_pass(0);
        do_pass(1);
        do_pass(2);
        do_pass(3);
        do_pass(5);
        for (int p = 0; p < 12; p++) do_pass(4);
        do_pass(1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
